// File: rtl/param_sync_ram_if.sv
// param_sync_ram_if: request/response bus between the CPU/ALU datapath and the RAM.
// parity_err exists only when PARAM_SYNC_RAM_PARITY_EN is defined.
interface param_sync_ram_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              cs;
  logic              wr;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] o;
  logic              o_valid;
  logic              busy;
  logic              addr_err;
`ifdef PARAM_SYNC_RAM_PARITY_EN
  logic              parity_err;

  modport master (
    output cs, wr, address, data,
    input  o, o_valid, busy, addr_err, parity_err
  );
  modport slave (
    input  cs, wr, address, data,
    output o, o_valid, busy, addr_err, parity_err
  );
`else
  modport master (
    output cs, wr, address, data,
    input  o, o_valid, busy, addr_err
  );
  modport slave (
    input  cs, wr, address, data,
    output o, o_valid, busy, addr_err
  );
`endif
endinterface

// File: rtl/param_sync_ram.sv
// param_sync_ram: single-port RAM, registered read, post-reset fill sweep.
// Define PARAM_SYNC_RAM_PARITY_EN to store and check an even-parity bit per word.
module param_sync_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH = 256,
  parameter logic [DATA_W-1:0] FILL_VALUE = '0
) (
  input logic             clock,
  input logic             reset,
  param_sync_ram_if.slave bus
);

`ifdef PARAM_SYNC_RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] IDLE  = 1'b1;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

  logic [MEM_W-1:0] ram_data [0:DEPTH-1];

  logic [0:0]        state_q, state_d;
  logic [ADDR_W:0]   clr_addr_q, clr_addr_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] o_q, o_d;
  logic              o_valid_q, o_valid_d;
  logic              addr_err_q, addr_err_d;
  logic              parity_err_q, parity_err_d;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [MEM_W-1:0]  wword;
  logic [MEM_W-1:0]  rword;
  logic              in_range;

  function automatic logic [MEM_W-1:0] pack(input logic [DATA_W-1:0] d);
`ifdef PARAM_SYNC_RAM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  assign in_range = {1'b0, bus.address} < LIMIT;
  assign rword = in_range ? ram_data[bus.address] : '0;

  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    busy_d       = busy_q;
    o_d          = o_q;
    o_valid_d    = 1'b0;
    addr_err_d   = 1'b0;
    parity_err_d = 1'b0;
    we           = 1'b0;
    waddr        = bus.address;
    wword        = pack(bus.data);
    unique case (state_q)
      CLEAR: begin
        we         = 1'b1;
        waddr      = clr_addr_q[ADDR_W-1:0];
        wword      = pack(FILL_VALUE);
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      IDLE: begin
        if (!bus.cs) begin
          addr_err_d = !in_range;
          if (bus.wr) begin
            we = in_range;
          end else begin
            o_valid_d = 1'b1;
            o_d = in_range ? rword[DATA_W-1:0] : FILL_VALUE;
`ifdef PARAM_SYNC_RAM_PARITY_EN
            parity_err_d = in_range &&
              (rword[DATA_W] != ^rword[DATA_W-1:0]);
`endif
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= CLEAR;
      clr_addr_q   <= '0;
      busy_q       <= 1'b1;
      o_q          <= '0;
      o_valid_q    <= 1'b0;
      addr_err_q   <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      busy_q       <= busy_d;
      o_q          <= o_d;
      o_valid_q    <= o_valid_d;
      addr_err_q   <= addr_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  // Storage has no reset; the sweep defines its contents.
  always_ff @(posedge clock) begin
    if (reset && we) begin
      ram_data[waddr] <= wword;
    end
  end

  assign bus.o        = o_q;
  assign bus.o_valid  = o_valid_q;
  assign bus.busy     = busy_q;
  assign bus.addr_err = addr_err_q;
`ifdef PARAM_SYNC_RAM_PARITY_EN
  assign bus.parity_err = parity_err_q;
`endif

endmodule
